// File: rtl/uart_rx_fifo_writer_if.sv
// Receive-FIFO write port: byte, push strobe and back-pressure flag.
interface uart_rx_fifo_writer_if;
    logic [7:0] rx_data;
    logic       rx_push;
    logic       full;

    modport master (
        output rx_data,
        output rx_push,
        input  full
    );

    modport slave (
        input  rx_data,
        input  rx_push,
        output full
    );
endinterface

// File: rtl/uart_rx_fifo_writer.sv
// 16x-oversampled UART receiver that pushes good bytes into the RX FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
module uart_rx_fifo_writer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    uart_rx_fifo_writer_if.master fifo,
    output logic rx_busy,
    output logic frame_err,
`ifdef UART_RX_PARITY_EN
    output logic parity_err,
`endif
    output logic overrun_err
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          w_tick;
    logic          w_rx_s;

    state_t        r_state, w_state;
    logic [3:0]    r_s, w_s;
    logic [2:0]    r_b, w_b;
    logic [7:0]    r_shreg, w_shreg;
    logic [7:0]    r_data, w_data;
    logic          r_armed, w_armed;
    logic          r_push, w_push;
    logic          r_ferr, w_ferr;
    logic          r_oerr, w_oerr;
    logic          w_par_bad;
`ifdef UART_RX_PARITY_EN
    logic          r_par, w_par;
    logic          r_perr, w_perr;
`endif

    assign w_rx_s = r_sync2;
    assign w_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data ones plus parity bit must be even.
    assign w_par_bad = ^r_shreg ^ r_par;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_b     <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_armed <= 1'b1;
            r_push  <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_b     <= w_b;
            r_shreg <= w_shreg;
            r_data  <= w_data;
            r_armed <= w_armed;
            r_push  <= w_push;
            r_ferr  <= w_ferr;
            r_oerr  <= w_oerr;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par;
            r_perr  <= w_perr;
`endif
        end
    end

    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_b     = r_b;
        w_shreg = r_shreg;
        w_data  = r_data;
        w_armed = r_armed;
        w_push  = 1'b0;
        w_ferr  = 1'b0;
        w_oerr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par   = r_par;
        w_perr  = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                // After a framing error the line must go high before a new start.
                if (!r_armed) begin
                    if (w_rx_s) w_armed = 1'b1;
                end else if (!w_rx_s) begin
                    w_state = S_START;
                    w_s     = '0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_s == 4'd7) begin
                        if (!w_rx_s) begin
                            w_state = S_DATA;
                            w_s     = '0;
                            w_b     = '0;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else begin
                        w_s = r_s + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_s == 4'd15) begin
                        w_shreg = {w_rx_s, r_shreg[7:1]};
                        w_s     = '0;
                        if (r_b == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            w_state = S_PARITY;
`else
                            w_state = S_STOP;
`endif
                        end else begin
                            w_b = r_b + 3'd1;
                        end
                    end else begin
                        w_s = r_s + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    if (r_s == 4'd15) begin
                        w_par   = w_rx_s;
                        w_s     = '0;
                        w_state = S_STOP;
                    end else begin
                        w_s = r_s + 4'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_s == 4'd15) begin
                        w_state = S_IDLE;
                        w_s     = '0;
                        w_armed = w_rx_s;
                        if (!w_rx_s) begin
                            w_ferr = 1'b1;
                        end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                            w_perr = 1'b1;
`endif
                        end else if (fifo.full) begin
                            w_data = r_shreg;
                            w_oerr = 1'b1;
                        end else begin
                            w_data = r_shreg;
                            w_push = 1'b1;
                        end
                    end else begin
                        w_s = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign fifo.rx_data = r_data;
    assign fifo.rx_push = r_push;
    assign rx_busy      = (r_state != S_IDLE);
    assign frame_err    = r_ferr;
    assign overrun_err  = r_oerr;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Randomized bench for uart_rx_fifo_writer against a frame-level outcome model.
// Runs at DIV=1 (16 clocks per bit).
module tb_uart_rx_fifo_writer;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BITCLK   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic rx_busy;
    logic frame_err;
    logic overrun_err;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    localparam bit PAR = 1'b1;
`else
    logic parity_err;
    assign parity_err = 1'b0;
    localparam bit PAR = 1'b0;
`endif

    uart_rx_fifo_writer_if fifo ();

    uart_rx_fifo_writer #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .fifo        (fifo),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_push = 0, n_ferr = 0, n_oerr = 0, n_perr = 0;
    int n_busy = 0, n_multi = 0;
    logic [7:0] last_push = 8'h00;
    logic [7:0] m_data = 8'h00;

    // Count high cycles of every strobe; a stretched pulse shows up as >1.
    always @(negedge clk) begin
        if (fifo.rx_push) begin
            n_push++;
            last_push = fifo.rx_data;
        end
        if (frame_err) n_ferr++;
        if (overrun_err) n_oerr++;
        if (parity_err) n_perr++;
        if (rx_busy) n_busy++;
        if (32'(fifo.rx_push) + 32'(frame_err) + 32'(overrun_err)
            + 32'(parity_err) > 1)
            n_multi++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic stop,
                             input logic fl, input logic par_ok,
                             input int gap);
        int p0, f0, o0, q0;
        int ep, ef, eo, eq;
        p0 = n_push; f0 = n_ferr; o0 = n_oerr; q0 = n_perr;
        ep = 0; ef = 0; eo = 0; eq = 0;
        fifo.full = fl;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR) send_bit(par_ok ? ^d : ~^d);
        send_bit(stop);
        if (!stop) ef = 1;
        else if (PAR && !par_ok) eq = 1;
        else if (fl) begin eo = 1; m_data = d; end
        else begin ep = 1; m_data = d; end
        chk("push", n_push - p0, ep);
        chk("frame_err", n_ferr - f0, ef);
        chk("overrun_err", n_oerr - o0, eo);
        chk("parity_err", n_perr - q0, eq);
        chk("rx_data", fifo.rx_data, m_data);
        if (ep != 0) chk("push_data", last_push, d);
        for (int i = 0; i < gap; i++) send_bit(1'b1);
    endtask

    initial begin
        int b0, p0, f0, o0;
        logic [7:0] d;
        logic st, fl, po;
        int gap;
        fifo.full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", fifo.rx_data, 8'h00);
        chk("rst_push", fifo.rx_push, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_oerr", overrun_err, 0);
        rst = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);

        run_frame(8'h55, 1'b1, 1'b0, 1'b1, 1);

        b0 = n_busy; p0 = n_push; f0 = n_ferr; o0 = n_oerr;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        chk("glitch_busy", 32'(n_busy > b0), 1);
        chk("glitch_idle", rx_busy, 0);
        chk("glitch_push", n_push - p0, 0);
        chk("glitch_err", (n_ferr - f0) + (n_oerr - o0), 0);

        run_frame(8'hA3, 1'b0, 1'b0, 1'b1, 1);
        run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1);
        run_frame(8'h00, 1'b1, 1'b0, 1'b1, 0);
        run_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1);

        p0 = n_push; f0 = n_ferr; o0 = n_oerr;
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_data = 8'h00;
        chk("midrst_data", fifo.rx_data, 8'h00);
        chk("midrst_busy", rx_busy, 0);
        chk("midrst_push", fifo.rx_push, 0);
        chk("midrst_err", 32'(frame_err) + 32'(overrun_err), 0);
        rst = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        chk("abort_push", n_push - p0, 0);
        chk("abort_err", (n_ferr - f0) + (n_oerr - o0), 0);
        run_frame(8'h81, 1'b1, 1'b0, 1'b1, 1);

        if (PAR) begin
            run_frame(8'h07, 1'b1, 1'b0, 1'b0, 1);
            run_frame(8'h07, 1'b1, 1'b0, 1'b1, 1);
        end

        for (int k = 0; k < 40; k++) begin
            d   = 8'($urandom);
            st  = ($urandom_range(7) != 0);
            fl  = ($urandom_range(3) == 0);
            po  = PAR ? ($urandom_range(4) != 0) : 1'b1;
            gap = st ? int'($urandom_range(2)) : 1 + int'($urandom_range(1));
            run_frame(d, st, fl, po, gap);
        end

        chk("exclusive", n_multi, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
